// File: rtl/walk_phase_controller.sv
// Pedestrian walk-phase controller: serves a latched walk request through a stop handshake
// with the vehicle sequencer. Define WALK_COUNTDOWN_EN to expose the FLASH timer on walk_countdown.
module walk_phase_controller #(
    parameter int CNT_W      = 8,
    parameter int WALK_TIME  = 10,
    parameter int FLASH_TIME = 6,
    parameter int MIN_GAP    = 20
) (
    input  logic             clk,
    input  logic             sys_reset,
    input  logic             tick,
    input  logic             walkRegister_status,
    output logic             walkRegister_reset,
    output logic             veh_stop_req,
    input  logic             veh_stopped,
    output logic             walk_light,
    output logic             dont_walk_light,
    output logic [CNT_W-1:0] walk_countdown,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_STOP,
        WALK,
        FLASH,
        CLEAR,
        COOLDOWN
    } state_t;

    // Zero-length phases are stretched to one tick so every phase is observable.
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] WALK_LD  = (WALK_TIME  == 0) ? ONE : CNT_W'(WALK_TIME);
    localparam logic [CNT_W-1:0] FLASH_LD = (FLASH_TIME == 0) ? ONE : CNT_W'(FLASH_TIME);
    localparam logic [CNT_W-1:0] GAP_LD   = (MIN_GAP    == 0) ? ONE : CNT_W'(MIN_GAP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             blink_q, blink_d;
    logic             pulse_q, pulse_d;
    logic             stopReq_q, stopReq_d;
    logic             walk_q, walk_d;
    logic             dontWalk_q, dontWalk_d;
    logic             busy_q, busy_d;
    logic             tickEff;

    assign tickEff = tick && (timer_q != '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        unique case (state_q)
            IDLE: begin
                if (walkRegister_status) begin
                    state_d = REQ_STOP;
                end
            end
            REQ_STOP: begin
                if (veh_stopped) begin
                    state_d = WALK;
                    timer_d = WALK_LD;
                end
            end
            WALK: begin
                if (tickEff) begin
                    if (timer_q == ONE) begin
                        state_d = FLASH;
                        timer_d = FLASH_LD;
                        blink_d = 1'b1;
                    end else begin
                        timer_d = timer_q - ONE;
                    end
                end
            end
            FLASH: begin
                if (tickEff) begin
                    if (timer_q == ONE) begin
                        state_d = CLEAR;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - ONE;
                        blink_d = ~blink_q;
                    end
                end
            end
            CLEAR: begin
                if (!veh_stopped) begin
                    state_d = COOLDOWN;
                    timer_d = GAP_LD;
                end
            end
            COOLDOWN: begin
                if (tickEff) begin
                    if (timer_q == ONE) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Lamp and handshake outputs are decoded from the next state so they register with it.
    always_comb begin
        pulse_d    = 1'b0;
        stopReq_d  = 1'b0;
        walk_d     = 1'b0;
        dontWalk_d = 1'b1;
        busy_d     = (state_d != IDLE);
        unique case (state_d)
            REQ_STOP: begin
                stopReq_d = 1'b1;
            end
            WALK: begin
                stopReq_d  = 1'b1;
                walk_d     = 1'b1;
                dontWalk_d = 1'b0;
                pulse_d    = (state_q != WALK);
            end
            FLASH: begin
                stopReq_d  = 1'b1;
                dontWalk_d = blink_d;
            end
            default: begin
                dontWalk_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            blink_q    <= 1'b0;
            pulse_q    <= 1'b0;
            stopReq_q  <= 1'b0;
            walk_q     <= 1'b0;
            dontWalk_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            blink_q    <= blink_d;
            pulse_q    <= pulse_d;
            stopReq_q  <= stopReq_d;
            walk_q     <= walk_d;
            dontWalk_q <= dontWalk_d;
            busy_q     <= busy_d;
        end
    end

    assign walkRegister_reset = pulse_q;
    assign veh_stop_req       = stopReq_q;
    assign walk_light         = walk_q;
    assign dont_walk_light    = dontWalk_q;
    assign busy               = busy_q;

`ifdef WALK_COUNTDOWN_EN
    logic [CNT_W-1:0] countdown_q;

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            countdown_q <= '0;
        end else begin
            countdown_q <= (state_d == FLASH) ? timer_d : '0;
        end
    end

    assign walk_countdown = countdown_q;
`else
    assign walk_countdown = '0;
`endif

endmodule

// File: doc/walk_phase_controller.md
Name: walk_phase_controller

Overview:
- Consumer side of the walk-request register.
- Samples the latched walk request (`walkRegister_status`) and asks the vehicle sequencer to stop traffic through a req/ack handshake.
- Runs the pedestrian WALK and flashing DON'T-WALK phases, then enforces a minimum gap before the next request can be served.
- Issues the one-cycle `walkRegister_reset` pulse that clears the latched request.

Parameters:
- CNT_W, 8, width of the phase-timer counter.
- WALK_TIME, 10, ticks spent in WALK; 0 is treated as 1.
- FLASH_TIME, 6, ticks spent in FLASH; 0 is treated as 1.
- MIN_GAP, 20, ticks spent in COOLDOWN before a new request is accepted; 0 is treated as 1.

Ports:
- clk  input  1  system clock, rising edge.
- sys_reset  input  1  asynchronous, active-low reset (0 = reset).
- tick  input  1  one-cycle timebase enable (nominally 1 Hz); all phase timing counts these.
- walkRegister_status  input  1  latched pedestrian request, level.
- walkRegister_reset  output  1  one-cycle pulse that clears the walk register.
- veh_stop_req  output  1  request to the vehicle sequencer to bring traffic to red, level.
- veh_stopped  input  1  acknowledge from the vehicle sequencer: traffic is held at red, level.
- walk_light  output  1  pedestrian WALK lamp.
- dont_walk_light  output  1  pedestrian DON'T-WALK lamp.
- walk_countdown  output  CNT_W  remaining FLASH ticks (optional feature).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (`sys_reset`=0, asynchronous):
  - State = IDLE, timer = 0, blink phase = 0.
  - `walkRegister_reset`=0, `veh_stop_req`=0, `walk_light`=0, `dont_walk_light`=1, `walk_countdown`=0, `busy`=0.
  - Reset mid-phase aborts immediately to these values. No pulse is issued, so a latched request survives in the walk register.
- Outputs are registered. Every state transition takes effect on the clk edge after its condition is seen.
- IDLE:
  - `dont_walk_light`=1.
  - If `walkRegister_status`=1 → REQ_STOP.
- REQ_STOP:
  - `veh_stop_req`=1, `dont_walk_light`=1.
  - Wait with no timeout. When `veh_stopped`=1 → WALK.
- WALK:
  - `veh_stop_req`=1, `walk_light`=1, `dont_walk_light`=0.
  - `walkRegister_reset`=1 for exactly the first cycle in WALK.
  - Timer loads WALK_TIME on entry and decrements on each tick.
  - On a tick with timer==1 → FLASH.
- FLASH:
  - `veh_stop_req`=1, `walk_light`=0.
  - `dont_walk_light` = blink phase. The blink phase loads 1 on entry and toggles on each tick.
  - Timer loads FLASH_TIME on entry. On a tick with timer==1 → CLEAR.
- CLEAR:
  - `veh_stop_req`=0, `dont_walk_light`=1 (steady).
  - When `veh_stopped`=0 → COOLDOWN.
- COOLDOWN:
  - `dont_walk_light`=1.
  - Timer loads MIN_GAP on entry. On a tick with timer==1 → IDLE.
  - `walkRegister_status` is ignored in this state.
- A tick arriving in the same cycle as state entry is not counted; counting starts on the cycle after entry.
- A tick is effective only when timer is nonzero. The timer saturates at 0 and never wraps.
- A button press during WALK/FLASH/CLEAR/COOLDOWN is latched by the walk register. Because the clear pulse was issued at WALK entry, that request is served after COOLDOWN with no extra logic.
- `veh_stopped` dropping during WALK/FLASH is a protocol violation. The controller ignores it and completes the phase.
- `busy` = (state != IDLE).

Optional Feature:
- WALK_COUNTDOWN_EN defined:
  - In FLASH, `walk_countdown` = current timer value: FLASH_TIME on entry, decrementing per tick.
  - In all other states it is 0.
- Not defined: `walk_countdown` is tied to 0, the port remains, and no additional registers are built.

Test Plan:
- Reset check: hold `sys_reset`=0 for 2 cycles, then release → `dont_walk_light`=1, all other outputs 0, `busy`=0.
- Full cycle: params 3/2/4, tick every 4 clocks, status=1, `veh_stopped` follows `veh_stop_req` after 2 cycles →
  - `veh_stop_req` rises 1 cycle after status.
  - WALK lasts 3 ticks, with a single `walkRegister_reset` pulse on its first cycle.
  - FLASH shows `dont_walk_light` 1,0 across its 2 ticks.
  - CLEAR, then COOLDOWN for 4 ticks, then IDLE.
- Handshake stall: hold `veh_stopped`=0 for 50 cycles → remain in REQ_STOP with `walk_light`=0 and no `walkRegister_reset` pulse. Raise it → WALK on the next edge.
- Re-request: press during FLASH (walk register re-latches) → after COOLDOWN expires, the controller re-enters REQ_STOP without a new press.
- Mid-phase reset: assert `sys_reset`=0 during WALK → outputs return to reset values asynchronously, before the next clk edge. After release, the controller sits in IDLE until status is high.
- With WALK_COUNTDOWN_EN, FLASH_TIME=6 → `walk_countdown` reads 6,5,4,3,2,1 across FLASH ticks, then 0 in CLEAR. Without the macro it is 0 throughout.
